// File: rtl/xgmii_rx_ctrl_pkg.sv
// Shared types for the XGMII receive-enable controller: FSM state encoding.
package xgmii_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARMING   = 2'd1,
    ST_ENABLED  = 2'd2,
    ST_DRAINING = 2'd3
  } rx_state_e;

endpackage

// File: rtl/xgmii_rx_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins, and clear with
// a coincident increment starts the new period at 1.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= WIDTH'(inc);
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/xgmii_rx_ctrl.sv
// Sequences the RX MAC enable against PHY lock, drains in-flight frames before
// disabling; optional frame statistics built only with XGMII_RX_CTRL_STATS_EN.
module xgmii_rx_ctrl
  import xgmii_rx_ctrl_pkg::*;
#(
  parameter int unsigned ARM_DELAY     = 16,
  parameter int unsigned DRAIN_TIMEOUT = 2048,
  parameter int unsigned COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_req,
  input  logic                   phy_ready,
  input  logic                   mon_tvalid,
  input  logic                   mon_tlast,
  input  logic                   mon_terr,
  input  logic                   mon_bad_fcs,
  input  logic                   stats_snap,
  output logic                   cfg_rx_enable,
  output logic                   rx_active,
  output logic                   rx_idle,
  output logic                   drain_abort,
  output logic [COUNT_WIDTH-1:0] stat_ok,
  output logic [COUNT_WIDTH-1:0] stat_err,
  output logic [COUNT_WIDTH-1:0] stat_fcs,
  output logic                   stat_valid
);

  localparam logic [15:0] ARM_LAST   = 16'(ARM_DELAY - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);

  rx_state_e   state, state_nxt;
  logic [15:0] arm_cnt, arm_nxt;
  logic [15:0] drain_cnt, drain_nxt;
  logic        in_frame, frame_nxt;
  logic        abort_nxt;

  always_comb begin
    state_nxt = state;
    arm_nxt   = arm_cnt;
    drain_nxt = drain_cnt;
    abort_nxt = 1'b0;
    frame_nxt = in_frame;
    if (mon_tvalid) frame_nxt = !mon_tlast;

    case (state)
      ST_DISABLED: begin
        if (en_req && phy_ready) begin
          state_nxt = ST_ARMING;
          arm_nxt   = '0;
        end
      end
      ST_ARMING: begin
        if (!en_req || !phy_ready) begin
          state_nxt = ST_DISABLED;
        end else if (arm_cnt == ARM_LAST) begin
          state_nxt = ST_ENABLED;
        end else begin
          arm_nxt = arm_cnt + 16'd1;
        end
      end
      ST_ENABLED: begin
        if (!en_req || !phy_ready) begin
          state_nxt = ST_DRAINING;
          drain_nxt = '0;
        end
      end
      ST_DRAINING: begin
        // Decision uses the registered frame flag so a closing tlast is
        // followed by exactly one more DRAINING cycle.
        if (!in_frame) begin
          state_nxt = ST_DISABLED;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nxt = ST_DISABLED;
          abort_nxt = 1'b1;
          frame_nxt = 1'b0;
        end else begin
          drain_nxt = drain_cnt + 16'd1;
        end
      end
      default: state_nxt = ST_DISABLED;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_DISABLED;
      arm_cnt       <= '0;
      drain_cnt     <= '0;
      in_frame      <= 1'b0;
      cfg_rx_enable <= 1'b0;
      rx_active     <= 1'b0;
      rx_idle       <= 1'b1;
      drain_abort   <= 1'b0;
    end else begin
      state         <= state_nxt;
      arm_cnt       <= arm_nxt;
      drain_cnt     <= drain_nxt;
      in_frame      <= frame_nxt;
      cfg_rx_enable <= (state_nxt == ST_ENABLED);
      rx_active     <= (state_nxt == ST_ENABLED);
      rx_idle       <= (state_nxt == ST_DISABLED);
      drain_abort   <= abort_nxt;
    end
  end

`ifdef XGMII_RX_CTRL_STATS_EN
  logic [COUNT_WIDTH-1:0] live_ok, live_err, live_fcs;
  logic                   eof;

  assign eof = mon_tvalid & mon_tlast;

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt_ok (
    .clk(clk), .rst_n(rst_n), .clr(stats_snap), .inc(eof & ~mon_terr), .cnt(live_ok)
  );
  sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt_err (
    .clk(clk), .rst_n(rst_n), .clr(stats_snap), .inc(eof & mon_terr), .cnt(live_err)
  );
  sat_counter #(.WIDTH(COUNT_WIDTH)) u_cnt_fcs (
    .clk(clk), .rst_n(rst_n), .clr(stats_snap), .inc(mon_bad_fcs), .cnt(live_fcs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok    <= '0;
      stat_err   <= '0;
      stat_fcs   <= '0;
      stat_valid <= 1'b0;
    end else begin
      stat_valid <= stats_snap;
      if (stats_snap) begin
        stat_ok  <= live_ok;
        stat_err <= live_err;
        stat_fcs <= live_fcs;
      end
    end
  end
`else
  logic unused_stats;

  assign unused_stats = ^{stats_snap, mon_terr, mon_bad_fcs};
  assign stat_ok      = '0;
  assign stat_err     = '0;
  assign stat_fcs     = '0;
  assign stat_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_xgmii_rx_ctrl.sv
// Self-checking bench for xgmii_rx_ctrl: FSM sequencing corner cases and a
// table-driven statistics run scored through a snapshot queue.
module tb_xgmii_rx_ctrl;

  logic clk = 1'b0;
  logic rst_n, en_req, phy_ready, mon_tvalid, mon_tlast, mon_terr, mon_bad_fcs, stats_snap;
  logic cfg_rx_enable, rx_active, rx_idle, drain_abort, stat_valid;
  logic [31:0] stat_ok, stat_err, stat_fcs;
  logic cfg_w, active_w, idle_w, abort_w, stat_valid_w;
  logic [3:0] stat_ok_w, stat_err_w, stat_fcs_w;

  always #5 clk = ~clk;

  xgmii_rx_ctrl #(.ARM_DELAY(16), .DRAIN_TIMEOUT(8), .COUNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .en_req(en_req), .phy_ready(phy_ready),
    .mon_tvalid(mon_tvalid), .mon_tlast(mon_tlast), .mon_terr(mon_terr),
    .mon_bad_fcs(mon_bad_fcs), .stats_snap(stats_snap),
    .cfg_rx_enable(cfg_rx_enable), .rx_active(rx_active), .rx_idle(rx_idle),
    .drain_abort(drain_abort), .stat_ok(stat_ok), .stat_err(stat_err),
    .stat_fcs(stat_fcs), .stat_valid(stat_valid)
  );

  xgmii_rx_ctrl #(.ARM_DELAY(16), .DRAIN_TIMEOUT(8), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en_req(en_req), .phy_ready(phy_ready),
    .mon_tvalid(mon_tvalid), .mon_tlast(mon_tlast), .mon_terr(mon_terr),
    .mon_bad_fcs(mon_bad_fcs), .stats_snap(stats_snap),
    .cfg_rx_enable(cfg_w), .rx_active(active_w), .rx_idle(idle_w),
    .drain_abort(abort_w), .stat_ok(stat_ok_w), .stat_err(stat_err_w),
    .stat_fcs(stat_fcs_w), .stat_valid(stat_valid_w)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has already raised en_req; counts edges until cfg_rx_enable rises.
  task automatic arm_time(input string name, input int exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cfg_rx_enable && n < 100);
    check(name, n, exp);
    check({name, "_active"}, rx_active, 1'b1);
    check({name, "_idle"}, rx_idle, 1'b0);
  endtask

  typedef struct {
    logic tv, tl, te, fcs, snap;
    int   exp_ok, exp_err, exp_fcs;
  } stats_vec_t;

  typedef struct {
    logic [31:0] ok, err, fcs;
  } snap_t;

  stats_vec_t vecs[14];
  snap_t      sb[$];
  snap_t      mon_e;

  always @(posedge clk) begin
    #1;
    if (rst_n && stat_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stat_valid_unexpected: got 1 expected 0");
      end else begin
        mon_e = sb.pop_front();
        check("snap_ok", stat_ok, mon_e.ok);
        check("snap_err", stat_err, mon_e.err);
        check("snap_fcs", stat_fcs, mon_e.fcs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    //            tv tl te fcs snap  ok err fcs
    vecs[0]  = '{1, 1, 0, 0, 0,   0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0,   0, 0, 0};
    vecs[2]  = '{1, 1, 1, 0, 0,   0, 0, 0};
    vecs[3]  = '{0, 0, 0, 1, 0,   0, 0, 0};
    vecs[4]  = '{1, 1, 0, 0, 0,   0, 0, 0};
    vecs[5]  = '{1, 1, 1, 0, 0,   0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0,   0, 0, 0};
    vecs[7]  = '{1, 1, 0, 0, 1,   3, 2, 1};
    vecs[8]  = '{0, 0, 0, 0, 0,   0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 1,   1, 0, 0};
    vecs[10] = '{1, 1, 1, 1, 0,   0, 0, 0};
    vecs[11] = '{0, 0, 0, 1, 1,   0, 1, 1};
    vecs[12] = '{0, 0, 0, 0, 1,   0, 0, 1};
    vecs[13] = '{0, 0, 0, 0, 0,   0, 0, 0};

    rst_n = 1'b0; en_req = 1'b0; phy_ready = 1'b0;
    mon_tvalid = 1'b0; mon_tlast = 1'b0; mon_terr = 1'b0;
    mon_bad_fcs = 1'b0; stats_snap = 1'b0;
    tick(); tick();
    check("rst_cfg", cfg_rx_enable, 1'b0);
    check("rst_active", rx_active, 1'b0);
    check("rst_idle", rx_idle, 1'b1);
    check("rst_abort", drain_abort, 1'b0);
    check("rst_stat_valid", stat_valid, 1'b0);
    check("rst_stat_ok", stat_ok, 0);
    rst_n = 1'b1;
    phy_ready = 1'b1;
    repeat (3) tick();
    check("idle_without_req", rx_idle, 1'b1);

    // Arm latency from en_req rising
    en_req = 1'b1;
    arm_time("arm_delay", 17);

    // 8-beat frame, en_req dropped on beat 3, frame completes inside the drain window
    for (int b = 1; b <= 8; b++) begin
      mon_tvalid = 1'b1;
      mon_tlast  = (b == 8);
      if (b == 3) en_req = 1'b0;
      tick();
      check("drain_no_abort", drain_abort, 1'b0);
      if (b == 3) begin
        check("drain_cfg_fall", cfg_rx_enable, 1'b0);
        check("drain_active_fall", rx_active, 1'b0);
        check("drain_not_idle", rx_idle, 1'b0);
      end
      if (b == 8) check("drain_tlast_still_draining", rx_idle, 1'b0);
    end
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
    tick();
    check("drain_done_idle", rx_idle, 1'b1);
    check("drain_done_abort", drain_abort, 1'b0);

    // Re-enable needs a full arm period; then a frame that never ends
    en_req = 1'b1;
    arm_time("rearm_after_drain", 17);
    mon_tvalid = 1'b1;
    tick();
    mon_tvalid = 1'b0;
    en_req = 1'b0;
    tick();
    check("timeout_entry_cfg", cfg_rx_enable, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!drain_abort && n < 50);
    check("drain_timeout_cycles", n, 8);
    check("timeout_idle", rx_idle, 1'b1);
    tick();
    check("abort_one_cycle", drain_abort, 1'b0);

    // Drain entered with no frame in flight lasts one cycle
    en_req = 1'b1;
    arm_time("arm_third", 17);
    en_req = 1'b0;
    tick();
    check("empty_drain_not_idle", rx_idle, 1'b0);
    tick();
    check("empty_drain_idle", rx_idle, 1'b1);
    check("empty_drain_abort", drain_abort, 1'b0);

    // phy_ready lost at arming cycle 10
    en_req = 1'b1;
    tick();
    check("arming_not_idle", rx_idle, 1'b0);
    repeat (10) tick();
    phy_ready = 1'b0;
    tick();
    check("phy_loss_idle", rx_idle, 1'b1);
    check("phy_loss_cfg", cfg_rx_enable, 1'b0);
    phy_ready = 1'b1;
    arm_time("rearm_fresh", 17);

    // Asynchronous reset while draining a frame
    mon_tvalid = 1'b1;
    tick();
    mon_tvalid = 1'b0;
    en_req = 1'b0;
    tick();
    check("pre_reset_draining", rx_idle, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_idle", rx_idle, 1'b1);
    check("async_rst_cfg", cfg_rx_enable, 1'b0);
    tick();
    rst_n = 1'b1;
    n = 0;
    repeat (10) begin
      tick();
      if (drain_abort) n++;
    end
    check("no_abort_after_reset", n, 0);

    // Statistics table; expected snapshots queued as the snap is driven
    foreach (vecs[i]) begin
      mon_tvalid  = vecs[i].tv;
      mon_tlast   = vecs[i].tl;
      mon_terr    = vecs[i].te;
      mon_bad_fcs = vecs[i].fcs;
      stats_snap  = vecs[i].snap;
`ifdef XGMII_RX_CTRL_STATS_EN
      if (vecs[i].snap)
        sb.push_back('{ok: vecs[i].exp_ok, err: vecs[i].exp_err, fcs: vecs[i].exp_fcs});
`endif
      tick();
    end
    mon_tvalid = 1'b0; mon_tlast = 1'b0; mon_terr = 1'b0;
    mon_bad_fcs = 1'b0; stats_snap = 1'b0;
    repeat (3) tick();

`ifdef XGMII_RX_CTRL_STATS_EN
    // Saturation on the 4-bit instance
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mon_tvalid = 1'b1;
    mon_tlast  = 1'b1;
    repeat (20) tick();
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
    stats_snap = 1'b1;
    sb.push_back('{ok: 32'd20, err: 32'd0, fcs: 32'd0});
    tick();
    stats_snap = 1'b0;
    check("sat_w4_ok", stat_ok_w, 4'd15);
    check("sat_w4_valid", stat_valid_w, 1'b1);
    tick();
    check("stat_valid_pulse", stat_valid, 1'b0);
    tick();
    check("scoreboard_drained", sb.size(), 0);
`else
    check("nostats_ok", stat_ok, 0);
    check("nostats_err", stat_err, 0);
    check("nostats_fcs", stat_fcs, 0);
    check("nostats_valid", stat_valid, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
